adda_stream: RTL and testbench

Parametrised ADC-to-DAC streaming engine for the ULX3S J2 AD/DA add-on.
- Generates the ADC and DAC conversion clocks from the system clock through a programmable divider.
- Captures ADC samples, optionally box-car averages them, and drives the DAC in one of four modes: passthrough, invert, test ramp, hold.
- Sits between the board top level (J2 pins, LEDs) and any downstream sample consumer, exposing a sample/valid stream.

---
 rtl/adda_pkg.sv | 15 +
 rtl/adda_clkdiv.sv | 41 ++++
 rtl/adda_stream.sv | 107 ++++++++++
 tb/tb_adda_stream.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/adda_pkg.sv
// Shared types and default sizing for the J2 AD/DA streaming engine.
package adda_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_INVERT = 2'd1,
    MODE_RAMP   = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_DIV_W   = 16;
  localparam int DEF_AVG_MAX = 3;

endpackage

// File: rtl/adda_clkdiv.sv
// Conversion clock divider: complementary ADC/DAC clocks plus edge ticks.
module adda_clkdiv #(
  parameter int DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_ad_clk,
  output logic             o_da_clk,
  output logic             o_fall_tick,
  output logic             o_rise_tick
);

  logic [DIV_W-1:0] cnt;
  logic             wrap;

  assign wrap        = (cnt >= i_div);
  assign o_fall_tick = i_en & wrap & o_ad_clk;
  assign o_rise_tick = i_en & wrap & ~o_ad_clk;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt      <= '0;
      o_ad_clk <= 1'b0;
      o_da_clk <= 1'b1;
    end else if (!i_en) begin
      cnt      <= '0;
      o_ad_clk <= 1'b0;
      o_da_clk <= 1'b1;
    end else if (wrap) begin
      cnt      <= '0;
      o_ad_clk <= ~o_ad_clk;
      // complement of the new ad_clk value, so both flip on the same edge
      o_da_clk <= o_ad_clk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adda_stream.sv
// ADC capture with box-car averaging, feeding the DAC through a mode mux.
module adda_stream
  import adda_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DIV_W   = DEF_DIV_W,
  parameter int AVG_MAX = DEF_AVG_MAX
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_en,
  input  logic [DIV_W-1:0]             i_div,
  input  logic [1:0]                   i_mode,
  input  logic [$clog2(AVG_MAX+1)-1:0] i_avg_log2,
  input  logic [DATA_W-1:0]            i_ad_data,
  output logic                         o_ad_clk,
  output logic                         o_da_clk,
  output logic [DATA_W-1:0]            o_da_data,
  output logic [DATA_W-1:0]            o_sample,
  output logic                         o_sample_valid
);

  localparam int ACC_W = DATA_W + AVG_MAX;
  localparam int CNT_W = (AVG_MAX > 0) ? AVG_MAX : 1;
  localparam int LOG_W = $clog2(AVG_MAX + 1);

  logic              fall_tick;
  logic              rise_tick;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  sum;
  logic [CNT_W-1:0]  smp_cnt;
  logic [LOG_W-1:0]  n_lat;
  logic [LOG_W-1:0]  n_req;
  logic [LOG_W-1:0]  n_use;
  logic              last;
  logic [DATA_W-1:0] ramp;
  logic [DATA_W-1:0] da_next;
  logic              pending;

  adda_clkdiv #(.DIV_W(DIV_W)) u_clkdiv (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_en        (i_en),
    .i_div       (i_div),
    .o_ad_clk    (o_ad_clk),
    .o_da_clk    (o_da_clk),
    .o_fall_tick (fall_tick),
    .o_rise_tick (rise_tick)
  );

  // Window size is taken live on the first sample, latched for the rest.
  assign n_req = (i_avg_log2 > LOG_W'(AVG_MAX)) ? LOG_W'(AVG_MAX) : i_avg_log2;
  assign n_use = (smp_cnt == '0) ? n_req : n_lat;
  assign sum   = acc + ACC_W'(i_ad_data);
  assign last  = (smp_cnt == CNT_W'((1 << n_use) - 1));

  always_comb begin
    da_next = o_da_data;
    case (mode_e'(i_mode))
      MODE_PASS:   da_next = o_sample;
      MODE_INVERT: da_next = ~o_sample;
      MODE_RAMP:   da_next = ramp;
      MODE_HOLD:   da_next = o_da_data;
      default:     da_next = o_da_data;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc            <= '0;
      smp_cnt        <= '0;
      n_lat          <= '0;
      ramp           <= '0;
      pending        <= 1'b0;
      o_sample       <= '0;
      o_sample_valid <= 1'b0;
      o_da_data      <= '0;
    end else if (!i_en) begin
      acc            <= '0;
      smp_cnt        <= '0;
      pending        <= 1'b0;
      o_sample_valid <= 1'b0;
    end else begin
      o_sample_valid <= 1'b0;
      if (fall_tick) begin
        if (smp_cnt == '0) n_lat <= n_req;
        if (last) begin
          o_sample       <= DATA_W'(sum >> n_use);
          o_sample_valid <= 1'b1;
          acc            <= '0;
          smp_cnt        <= '0;
          ramp           <= ramp + 1'b1;
          pending        <= 1'b1;
        end else begin
          acc     <= sum;
          smp_cnt <= smp_cnt + 1'b1;
        end
      end
      // DAC word moves only on rise ticks, half a period before the DAC latches it
      if (rise_tick && pending) begin
        pending   <= 1'b0;
        o_da_data <= da_next;
      end
    end
  end

endmodule

// File: tb/tb_adda_stream.sv
// Self-checking bench for adda_stream against a period-arithmetic reference model.
module tb_adda_stream;
  import adda_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] div = '0;
  logic [1:0]  mode = '0;
  logic [1:0]  avg = '0;
  logic [7:0]  ad = '0;
  logic        ad_clk, da_clk, valid;
  logic [7:0]  da_data, sample;

  int checks = 0;
  int failures = 0;

  // reference model state
  int         k;
  bit         m_ad;
  bit         m_valid;
  bit         m_pend;
  logic [7:0] m_sample, m_da, m_ramp;
  int         n_win;
  logic [7:0] q[$];

  adda_stream #(.DATA_W(8), .DIV_W(16), .AVG_MAX(3)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_en           (en),
    .i_div          (div),
    .i_mode         (mode),
    .i_avg_log2     (avg),
    .i_ad_data      (ad),
    .o_ad_clk       (ad_clk),
    .o_da_clk       (da_clk),
    .o_da_data      (da_data),
    .o_sample       (sample),
    .o_sample_valid (valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    k = 0; m_ad = 0; m_valid = 0; m_pend = 0;
    m_sample = '0; m_da = '0; m_ramp = '0; n_win = 0;
    q.delete();
  endtask

  task automatic check_all();
    chk("ad_clk", 8'(ad_clk), 8'(m_ad));
    chk("da_clk", 8'(da_clk), 8'(!m_ad));
    chk("valid", 8'(valid), 8'(m_valid));
    chk("sample", sample, m_sample);
    chk("da_data", da_data, m_da);
  endtask

  // One clock: model the edge from the inputs currently applied, then compare.
  task automatic step();
    int p;
    int ph;
    int sum;
    @(posedge clk);
    if (!en) begin
      k = 0; q.delete(); m_ad = 0; m_valid = 0; m_pend = 0;
    end else begin
      p  = int'(div) + 1;
      ph = (k + 1) % (2 * p);
      m_valid = 0;
      if (ph == p && m_pend) begin
        case (mode)
          2'd0: m_da = m_sample;
          2'd1: m_da = ~m_sample;
          2'd2: m_da = m_ramp;
          default: ;
        endcase
        m_pend = 0;
      end
      if (ph == 0) begin
        if (q.size() == 0) n_win = int'(avg);
        q.push_back(ad);
        if (q.size() == (1 << n_win)) begin
          sum = 0;
          foreach (q[i]) sum += int'(q[i]);
          m_sample = 8'(sum >> n_win);
          m_valid = 1; m_pend = 1; m_ramp = m_ramp + 8'd1;
          q.delete();
        end
      end
      k++;
      m_ad = ((k / p) % 2) == 1;
    end
    #1;
    check_all();
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    step();

    // div=0, n=0, PASS, stepping input
    div = 16'd0; avg = 2'd0; mode = MODE_PASS; en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      ad = 8'h10 + 8'(i);
      step();
    end

    // div=3, n=2, one value per sample 0x40..0x43
    en = 1'b0; step();
    div = 16'd3; avg = 2'd2; en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      ad = 8'h40 + 8'((k / 8) % 4);
      step();
    end
    chk("mean_0x41", sample, 8'h41);

    // INVERT
    en = 1'b0; step();
    div = 16'd0; avg = 2'd0; mode = MODE_INVERT; ad = 8'h3C; en = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("invert_c3", da_data, 8'hC3);

    // RAMP over 600 windows, n=1
    en = 1'b0; step();
    avg = 2'd1; mode = MODE_RAMP; en = 1'b1;
    for (int i = 0; i < 2404; i++) begin
      ad = 8'($urandom);
      step();
    end

    // HOLD at 0x55, then back to PASS
    en = 1'b0; step();
    avg = 2'd0; mode = MODE_PASS; ad = 8'h55; en = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("pre_hold_55", da_data, 8'h55);
    mode = MODE_HOLD;
    for (int i = 0; i < 20; i++) begin
      ad = 8'($urandom);
      step();
    end
    chk("hold_55", da_data, 8'h55);
    mode = MODE_PASS; ad = 8'h77;
    for (int i = 0; i < 4; i++) step();
    chk("unhold_77", da_data, 8'h77);

    // disable mid-window (n=3 after 5 samples), then re-enable
    en = 1'b0; step();
    div = 16'd1; avg = 2'd3; en = 1'b1;
    for (int i = 0; i < 22; i++) begin
      ad = 8'($urandom);
      step();
    end
    en = 1'b0;
    for (int i = 0; i < 4; i++) step();
    en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ad = 8'($urandom);
      step();
    end

    // randomized segments: mode, window and enable vary, divider fixed per segment
    for (int s = 0; s < 8; s++) begin
      en = 1'b0; step();
      div = 16'($urandom_range(0, 4));
      for (int i = 0; i < 200; i++) begin
        en   = ($urandom_range(0, 49) != 0);
        mode = 2'($urandom);
        if ($urandom_range(0, 15) == 0) avg = 2'($urandom);
        ad   = 8'($urandom);
        step();
      end
    end

    // async reset mid-window
    en = 1'b0; step();
    div = 16'd1; avg = 2'd3; mode = MODE_PASS; en = 1'b1;
    for (int i = 0; i < 70; i++) begin
      ad = 8'($urandom);
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ad = 8'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
